// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg -- shared types and constants for the UART transmit scheduler.
//   state_t    : scheduler FSM states
//   HDR_BASE   : header byte base; the served requester index is OR-ed in
//   CUR_ID_W   : width of the requester index (cur_id, last grant)
// Optional feature macro used by the scheduler: UART_TX_SCHED_HDR_EN.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_SEND,
    ST_WAIT_LO,
    ST_WAIT_HI
  } state_t;

  localparam logic [7:0] HDR_BASE = 8'hA0;
  localparam int         CUR_ID_W = 3;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter -- combinational round-robin picker.
// Ports:
//   i_req        : request vector, one bit per requester
//   i_last_grant : index of the previous winner; search starts one above it
//   o_grant      : one-hot winner (all zero when no request)
//   o_index      : binary index of the winner (0 when no request)
module rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]     i_req,
  input  logic [CUR_ID_W-1:0] i_last_grant,
  output logic [NREQ-1:0]     o_grant,
  output logic [CUR_ID_W-1:0] o_index
);

  int w_dist;
  int w_best;

  // Each requester's distance above last_grant (mod NREQ); smallest set one wins.
  always_comb begin
    o_grant = '0;
    o_index = '0;
    w_dist  = 0;
    w_best  = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i + 2 * NREQ - int'(i_last_grant) - 1) % NREQ;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best     = w_dist;
        o_grant    = '0;
        o_grant[i] = 1'b1;
        o_index    = CUR_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched -- round-robin scheduler feeding bytes from NREQ requesters
// into a single UART transmitter, one byte per grant.
// Optional feature: define UART_TX_SCHED_HDR_EN to precede every data byte
// with a header byte (HDR_BASE | requester index).
// Ports:
//   hwclk     : system clock, rising edge
//   reset     : asynchronous active-high reset
//   req       : level requests, held until acked
//   req_data  : one byte per requester, requester i at [8i+7:8i]
//   ack       : one-cycle pulse, byte of that requester latched
//   txdata    : byte presented to the transmitter
//   txclk     : one-cycle load strobe to the transmitter
//   txready   : transmitter can accept a byte
//   busy      : scheduler not idle
//   cur_id    : index of the requester being served
//   sent_cnt  : bytes strobed out (wraps)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for txready and a request; grant happens here
// ST_HDR     | strobe header byte (UART_TX_SCHED_HDR_EN only)
// ST_SEND    | strobe the latched data byte
// ST_WAIT_LO | wait for txready to drop, BUSY_TO-cycle timeout
// ST_WAIT_HI | wait for txready to return
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int BUSY_TO = 15
) (
  input  logic                hwclk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*8-1:0]   req_data,
  output logic [NREQ-1:0]     ack,
  output logic [7:0]          txdata,
  output logic                txclk,
  input  logic                txready,
  output logic                busy,
  output logic [CUR_ID_W-1:0] cur_id,
  output logic [15:0]         sent_cnt
);

  localparam int TMR_W = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(BUSY_TO - 1);

  state_t              r_state;
  logic [NREQ-1:0]     r_ack;
  logic [7:0]          r_txdata;
  logic                r_txclk;
  logic [CUR_ID_W-1:0] r_cur_id;
  logic [CUR_ID_W-1:0] r_last;
  logic [15:0]         r_sent_cnt;
  logic [TMR_W-1:0]    r_tmr;
`ifdef UART_TX_SCHED_HDR_EN
  logic [7:0]          r_byte;
  logic                r_hdr_phase;
`endif

  logic [NREQ-1:0]     w_grant;
  logic [CUR_ID_W-1:0] w_idx;
  logic [7:0]          w_sel;
  logic                w_wait_done;
  state_t              w_done_state;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req        (req),
    .i_last_grant (r_last),
    .o_grant      (w_grant),
    .o_index      (w_idx)
  );

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_idx == CUR_ID_W'(i)) w_sel = req_data[i*8 +: 8];
    end
  end

  // A timed-out WAIT_LO counts as accepted, same as a full low/high handshake.
  assign w_wait_done = txready &&
                       (((r_state == ST_WAIT_LO) && (r_tmr == '0)) || (r_state == ST_WAIT_HI));

  always_comb begin
`ifdef UART_TX_SCHED_HDR_EN
    w_done_state = r_hdr_phase ? ST_SEND : ST_IDLE;
`else
    w_done_state = ST_IDLE;
`endif
  end

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ack       <= '0;
      r_txdata    <= '0;
      r_txclk     <= 1'b0;
      r_cur_id    <= '0;
      r_last      <= CUR_ID_W'(NREQ - 1);
      r_sent_cnt  <= '0;
      r_tmr       <= '0;
`ifdef UART_TX_SCHED_HDR_EN
      r_byte      <= '0;
      r_hdr_phase <= 1'b0;
`endif
    end else begin
      r_ack   <= '0;
      r_txclk <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (txready && (req != '0)) begin
            r_ack    <= w_grant;
            r_cur_id <= w_idx;
            r_last   <= w_idx;
`ifdef UART_TX_SCHED_HDR_EN
            r_byte   <= w_sel;
            r_txdata <= HDR_BASE | {{(8-CUR_ID_W){1'b0}}, w_idx};
            r_state  <= ST_HDR;
`else
            r_txdata <= w_sel;
            r_state  <= ST_SEND;
`endif
          end
        end
`ifdef UART_TX_SCHED_HDR_EN
        ST_HDR: begin
          r_txclk     <= 1'b1;
          r_sent_cnt  <= r_sent_cnt + 16'd1;
          r_tmr       <= TMR_LOAD;
          r_hdr_phase <= 1'b1;
          r_state     <= ST_WAIT_LO;
        end
`endif
        ST_SEND: begin
          r_txclk    <= 1'b1;
          r_sent_cnt <= r_sent_cnt + 16'd1;
          r_tmr      <= TMR_LOAD;
          r_state    <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (w_wait_done)   r_state <= w_done_state;
          else if (!txready) r_state <= ST_WAIT_HI;
          else               r_tmr   <= r_tmr - TMR_W'(1);
        end
        ST_WAIT_HI: begin
          if (w_wait_done) r_state <= w_done_state;
        end
        default: r_state <= ST_IDLE;
      endcase
`ifdef UART_TX_SCHED_HDR_EN
      // Header handshake finished: present the data byte for SEND.
      if (w_wait_done && r_hdr_phase) begin
        r_txdata    <= r_byte;
        r_hdr_phase <= 1'b0;
      end
`endif
    end
  end

  assign ack      = r_ack;
  assign txdata   = r_txdata;
  assign txclk    = r_txclk;
  assign busy     = (r_state != ST_IDLE);
  assign cur_id   = r_cur_id;
  assign sent_cnt = r_sent_cnt;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched -- self-checking bench for uart_tx_sched (NREQ=4, BUSY_TO=15).
// Honours UART_TX_SCHED_HDR_EN when the build defines it.
module tb_uart_tx_sched;

  localparam int NREQ    = 4;
  localparam int BUSY_TO = 15;

  logic        hwclk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [7:0]  txdata;
  logic        txclk;
  logic        txready;
  logic        busy;
  logic [2:0]  cur_id;
  logic [15:0] sent_cnt;

  uart_tx_sched #(.NREQ(NREQ), .BUSY_TO(BUSY_TO)) dut (
    .hwclk    (hwclk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .txdata   (txdata),
    .txclk    (txclk),
    .txready  (txready),
    .busy     (busy),
    .cur_id   (cur_id),
    .sent_cnt (sent_cnt)
  );

  always #5 hwclk = ~hwclk;

  int checks = 0;
  int errors = 0;

  // Transmitter model: manual level, or auto (low for lo_len cycles after a strobe).
  logic tx_auto  = 1'b0;
  logic tx_force = 1'b1;
  int   lo_len   = 0;
  int   lo_left  = 0;

  always @(posedge hwclk) begin
    #1;
    if (!tx_auto || reset) begin
      lo_left = 0;
      txready = tx_auto ? 1'b1 : tx_force;
    end else begin
      if (txclk) lo_left = lo_len;
      if (lo_left > 0) begin
        txready = 1'b0;
        lo_left--;
      end else begin
        txready = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out", nm);
  endtask

  task automatic wait_ack(input string nm, output logic [3:0] a, output int cyc);
    a = '0;
    for (cyc = 1; cyc <= 300; cyc++) begin
      @(negedge hwclk);
      if (ack !== 4'b0) begin
        a = ack;
        return;
      end
    end
    timeout_fail(nm);
  endtask

  task automatic wait_txclk(input string nm, output logic [7:0] d);
    d = '0;
    for (int c = 0; c < 300; c++) begin
      @(negedge hwclk);
      if (txclk === 1'b1) begin
        d = txdata;
        return;
      end
    end
    timeout_fail(nm);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    @(negedge hwclk);
    @(negedge hwclk);
    reset = 1'b0;
  endtask

  // Round-robin rule: first set request strictly above the last winner, wrapping.
  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int pp;
      pp = (last + k) % NREQ;
      if (r[pp[1:0]]) return pp;
    end
    return -1;
  endfunction

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  exp_ack;
    logic [7:0]  exp_byte;
    logic [2:0]  exp_id;
  } vec_t;

  vec_t tbl[6];

  // Random-phase model state
  int         m_last;
  int         m_cnt;
  int         n_tx;
  logic [7:0] exp_q[$];

  task automatic rnd_step(input bit gen);
    int         p;
    logic [7:0] e;
    if (ack !== 4'b0) begin
      p = rr_pick(req, m_last);
      chk("rnd_ack", ack, (p < 0) ? 32'd0 : (32'd1 << p));
      if (p >= 0) begin
        m_last = p;
        chk("rnd_busy", busy, 1);
        chk("rnd_cur_id", cur_id, p);
`ifdef UART_TX_SCHED_HDR_EN
        chk("rnd_grant_txdata", txdata, 8'hA0 | p[7:0]);
        exp_q.push_back(8'hA0 | p[7:0]);
`else
        chk("rnd_grant_txdata", txdata, req_data[p*8 +: 8]);
`endif
        exp_q.push_back(req_data[p*8 +: 8]);
        n_tx++;
      end
    end
    if (txclk === 1'b1) begin
      if (exp_q.size() == 0) begin
        timeout_fail("rnd_unexpected_strobe");
      end else begin
        e = exp_q.pop_front();
        chk("rnd_strobe_byte", txdata, e);
        m_cnt++;
        chk("rnd_sent_cnt", sent_cnt, m_cnt & 16'hFFFF);
      end
      lo_len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
    end
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i] === 1'b1) begin
        req[i] = 1'b0;
      end else if (gen) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i]             = 1'b1;
          req_data[i*8 +: 8] = 8'($urandom);
        end else if (req[i] && $urandom_range(0, 47) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] a;
    logic [7:0] d;
    int         cyc;
    int         n_ack;
    int         n_clk;
    int         gap;
    bit         got;

    tbl[0] = '{4'b0001, 32'h0000_0041, 4'b0001, 8'h41, 3'd0};
    tbl[1] = '{4'b1000, 32'h5A00_0000, 4'b1000, 8'h5A, 3'd3};
    tbl[2] = '{4'b1001, 32'h9900_0011, 4'b0001, 8'h11, 3'd0};
    tbl[3] = '{4'b0110, 32'h0022_3300, 4'b0010, 8'h33, 3'd1};
    tbl[4] = '{4'b1100, 32'hF0E0_0000, 4'b0100, 8'hE0, 3'd2};
    tbl[5] = '{4'b0100, 32'h007E_0000, 4'b0100, 8'h7E, 3'd2};

    reset    = 1'b1;
    req      = '0;
    req_data = '0;
    repeat (3) @(negedge hwclk);
    chk("rst_ack", ack, 0);
    chk("rst_txclk", txclk, 0);
    chk("rst_txdata", txdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cur_id", cur_id, 0);
    chk("rst_sent_cnt", sent_cnt, 0);

    // Single transactions from reset: last_grant starts at NREQ-1.
    for (int t = 0; t < 6; t++) begin
      tx_auto = 1'b1;
      lo_len  = 2;
      do_reset();
      req_data = tbl[t].data;
      req      = tbl[t].req;
      wait_ack($sformatf("tbl%0d_ack_wait", t), a, cyc);
      chk($sformatf("tbl%0d_ack", t), a, tbl[t].exp_ack);
      chk($sformatf("tbl%0d_cur_id", t), cur_id, tbl[t].exp_id);
`ifdef UART_TX_SCHED_HDR_EN
      chk($sformatf("tbl%0d_grant_txdata", t), txdata, 8'hA0 | {5'b0, tbl[t].exp_id});
`else
      chk($sformatf("tbl%0d_grant_txdata", t), txdata, tbl[t].exp_byte);
`endif
      req = '0;
`ifdef UART_TX_SCHED_HDR_EN
      wait_txclk($sformatf("tbl%0d_hdr_wait", t), d);
      chk($sformatf("tbl%0d_hdr_byte", t), d, 8'hA0 | {5'b0, tbl[t].exp_id});
`endif
      wait_txclk($sformatf("tbl%0d_strobe_wait", t), d);
      chk($sformatf("tbl%0d_strobe_byte", t), d, tbl[t].exp_byte);
      chk($sformatf("tbl%0d_busy", t), busy, 1);
`ifdef UART_TX_SCHED_HDR_EN
      chk($sformatf("tbl%0d_sent_cnt", t), sent_cnt, 2);
`else
      chk($sformatf("tbl%0d_sent_cnt", t), sent_cnt, 1);
`endif
    end

    // All four requesting: round-robin order 0,1,2,3,0.
    tx_auto = 1'b1;
    lo_len  = 10;
    do_reset();
    req_data = 32'h4443_4241;
    req      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack($sformatf("rr%0d_wait", k), a, cyc);
      chk($sformatf("rr%0d_ack", k), a, 4'b0001 << (k % 4));
`ifdef UART_TX_SCHED_HDR_EN
      chk($sformatf("rr%0d_txdata", k), txdata, 8'hA0 | 8'(k % 4));
`else
      chk($sformatf("rr%0d_txdata", k), txdata, 8'h41 + 8'(k % 4));
`endif
    end
    req = '0;

    // txready held low: no grant; grant follows the release.
    tx_auto  = 1'b0;
    tx_force = 1'b0;
    do_reset();
    req_data = 32'h0000_5500;
    req      = 4'b0010;
    n_ack = 0;
    n_clk = 0;
    repeat (20) begin
      @(negedge hwclk);
      if (ack !== 4'b0) n_ack++;
      if (txclk !== 1'b0) n_clk++;
    end
    chk("rdy_lo_no_ack", n_ack, 0);
    chk("rdy_lo_no_txclk", n_clk, 0);
    chk("rdy_lo_busy", busy, 0);
    tx_force = 1'b1;
    wait_ack("rdy_hi_wait", a, cyc);
    chk("rdy_hi_ack", a, 4'b0010);
    chk("rdy_hi_latency", cyc, 2);
    req = '0;

    // txready stuck high after strobe: BUSY_TO timeout, then next grant.
    tx_auto = 1'b1;
    lo_len  = 0;
    do_reset();
    req_data = 32'h0000_2211;
    req      = 4'b0001;
    wait_ack("to_first_wait", a, cyc);
    req = 4'b0010;
    gap = -1;
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge hwclk);
      if (txclk === 1'b1) gap = 0;
      else if (gap >= 0) gap++;
      if (ack !== 4'b0) got = 1'b1;
    end
    chk("to_next_ack", ack, 4'b0010);
    chk("to_gap", gap, BUSY_TO + 1);
    req = '0;

    // Reset during WAIT_HI aborts; latched byte is not resent.
    tx_auto = 1'b1;
    lo_len  = 5;
    do_reset();
    req_data = 32'h0000_00C7;
    req      = 4'b0001;
    wait_ack("wh_ack_wait", a, cyc);
    req = '0;
    wait_txclk("wh_strobe_wait", d);
    @(negedge hwclk);
    chk("wh_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk("wh_rst_ack", ack, 0);
    chk("wh_rst_txclk", txclk, 0);
    chk("wh_rst_txdata", txdata, 0);
    chk("wh_rst_busy", busy, 0);
    chk("wh_rst_cur_id", cur_id, 0);
    chk("wh_rst_sent_cnt", sent_cnt, 0);
    @(negedge hwclk);
    reset = 1'b0;
    n_clk = 0;
    repeat (20) begin
      @(negedge hwclk);
      if (txclk !== 1'b0) n_clk++;
    end
    chk("wh_no_resend", n_clk, 0);
    req_data = 32'h3300_0000;
    req      = 4'b1000;
    wait_ack("wh_after_wait", a, cyc);
    chk("wh_after_ack", a, 4'b1000);
    req = '0;

    // Randomized traffic against the reference model.
    tx_auto = 1'b1;
    lo_len  = 2;
    do_reset();
    m_last = NREQ - 1;
    m_cnt  = 0;
    n_tx   = 0;
    exp_q.delete();
    for (int c = 0; c < 20000 && n_tx < 60; c++) begin
      @(negedge hwclk);
      rnd_step(1'b1);
    end
    if (n_tx < 60) timeout_fail("rnd_transactions");
    for (int c = 0; c < 400 && (exp_q.size() != 0 || busy); c++) begin
      @(negedge hwclk);
      rnd_step(1'b0);
    end
    chk("rnd_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter BUSY_TO, default 15, cycles to wait for txready to drop after a strobe.
REQ-003 SHALL have port hwclk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req, input, NREQ, level request per requester; held until acked.
REQ-006 SHALL have port req_data, input, NREQ*8, byte per requester; requester i uses bits [8i+7:8i].
REQ-007 SHALL have port ack, output, NREQ, one-cycle pulse; the byte of that requester is latched.
REQ-008 SHALL have port txdata, output, 8, byte presented to the UART transmitter.
REQ-009 SHALL have port txclk, output, 1, one-cycle load strobe to the transmitter.
REQ-010 SHALL have port txready, input, 1, high when the transmitter can accept a byte.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-012 SHALL have port cur_id, output, 3, index of the requester being served.
REQ-013 SHALL have port sent_cnt, output, 16, count of bytes strobed out.

Function
REQ-014 SHALL implement states IDLE, HDR, SEND, WAIT_LO, WAIT_HI.
REQ-015 IDLE: when txready=1 and req!=0, SHALL grant the first set req bit searching upward from (last_grant+1) mod NREQ.
- Same edge: latch req_data into txdata, load cur_id, pulse ack[winner].
- Next state: HDR when the macro is defined, else SEND.
REQ-016 SHALL make no grant in IDLE while txready=0; ack stays 0.
REQ-017 SEND: SHALL drive txclk=1 for exactly one cycle with txdata stable, increment sent_cnt, then go to WAIT_LO.
REQ-018 WAIT_LO: SHALL go to WAIT_HI on txready=0.
- If txready stays 1 for BUSY_TO cycles, SHALL go to IDLE anyway (strobe treated as accepted).
REQ-019 WAIT_HI: SHALL go to IDLE on txready=1; the earliest next grant is that IDLE cycle.
REQ-020 SHALL hold txdata and cur_id stable from the grant until the next grant.
REQ-021 sent_cnt SHALL wrap 16'hFFFF -> 16'h0000 silently.
REQ-022 A req deasserted before its grant SHALL be dropped without error.
- Simultaneous requests SHALL be served one per transaction in round-robin order.
REQ-023 SHALL accept no new grant until the current transaction returns to IDLE; no buffering beyond one byte.
REQ-024 ack SHALL be one-hot or zero in every cycle.

Reset
REQ-025 On reset=1, SHALL go to IDLE immediately, independent of hwclk.
- Outputs: txdata=0, txclk=0, ack=0, busy=0, cur_id=0, sent_cnt=0, last_grant=NREQ-1 (requester 0 first).
REQ-026 Reset mid-transaction SHALL abort it; the latched byte is discarded and not re-requested.

Configuration
REQ-027 Macro UART_TX_SCHED_HDR_EN, when defined, SHALL enable the header byte.
- HDR state drives txdata=8'hA0|cur_id and pulses txclk.
- It then waits txready low/high (same rules as WAIT_LO/WAIT_HI) and goes to SEND with the data byte.
- sent_cnt counts both bytes.
REQ-028 Without UART_TX_SCHED_HDR_EN, SHALL contain no HDR state logic; exactly one byte per grant.

Structure
REQ-029 Package uart_sched_pkg SHALL hold:
- state enum;
- header base constant 8'hA0;
- cur_id width constant.
REQ-030 Round-robin search SHALL be sub-module rr_arbiter: inputs req and last_grant, outputs one-hot grant and index; purely combinational.

Verification
REQ-031 Reset, req=4'b0001, data0=8'h41, txready=1: ack[0] one cycle, txclk one cycle with txdata=8'h41, sent_cnt=1.
REQ-032 req=4'b1111 held, transmitter model drops txready one cycle after txclk for 10 cycles: grants 0,1,2,3,0 in order.
REQ-033 txready=0 with req=4'b0010 for 20 cycles: no ack, no txclk; grant on the first cycle after txready=1.
REQ-034 txready stuck at 1 after strobe: return to IDLE after 15 cycles; next grant proceeds.
REQ-035 Reset asserted in WAIT_HI: all outputs zero that cycle; after release, req=4'b1000 wins over nothing pending, and requester 0 wins when both are set.
REQ-036 With UART_TX_SCHED_HDR_EN, req=4'b0100, data2=8'h7E: strobes 8'hA2 then 8'h7E; sent_cnt=2.
